// File: rtl/input_interrupt_arbiter.sv
// Frame-tick generator, key synchroniser/debouncer and sticky interrupt cause
// arbiter. Presents one interrupt instruction at a time to the CPU using a
// valid/ack handshake, so short events are never lost.
module input_interrupt_arbiter #(
  parameter int unsigned CLK_FREQ        = 50000000,
  parameter int unsigned FRAME_RATE      = 60,
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter bit          LEVEL_MODE      = 1'b0,
  parameter logic [4:0]  INT_OPCODE      = 5'b11111
) (
  input  logic                proc_clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] keys,
  input  logic [NUM_KEYS-1:0] key_mask,
  input  logic                int_ack,
  output logic                int_valid,
  output logic [31:0]         interrupt_instruction,
  output logic                frame_tick,
  output logic [NUM_KEYS:0]   pending,
  output logic [7:0]          missed_frames
);

  localparam logic [31:0] LIMIT = 32'(CLK_FREQ / FRAME_RATE) - 32'd1;
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, GAP = 2'd2} state_t;

  // Highest-priority pending cause: lowest key index wins, frame cause last.
  function automatic logic [4:0] pick_cause(input logic [NUM_KEYS:0] p);
    logic [4:0] c;
    c = 5'd0;
    for (int i = int'(NUM_KEYS); i >= 1; i--) begin
      c = p[i] ? 5'(i) : c;
    end
    return c;
  endfunction

  logic [31:0]         frame_cnt_r;
  logic [31:0]         frame_cnt_next_s;
  logic                frame_tick_r;
  logic [NUM_KEYS-1:0] sync1_r;
  logic [NUM_KEYS-1:0] sync2_r;
  logic [NUM_KEYS-1:0] deb_r;
  logic [NUM_KEYS-1:0] deb_d_r;
  logic [DB_W-1:0]     db_cnt_r [NUM_KEYS];
  logic [NUM_KEYS-1:0] key_set_s;
  logic [NUM_KEYS:0]   set_s;
  logic [NUM_KEYS:0]   clr_s;
  logic [NUM_KEYS:0]   pending_r;
  logic [NUM_KEYS:0]   pending_next_s;
  logic                ack_take_s;
  logic [7:0]          missed_r;
  state_t              state_r;
  state_t              state_next_s;
  logic                valid_r;
  logic                valid_next_s;
  logic [31:0]         instr_r;
  logic [31:0]         instr_next_s;
  logic [4:0]          cause_sel_r;
  logic [4:0]          cause_next_s;
  logic [4:0]          pick_s;

  // Frame counter wrap computation.
  always_comb begin
    frame_cnt_next_s = 32'd0;
    if (frame_cnt_r == LIMIT) begin
      frame_cnt_next_s = 32'd0;
    end else begin
      frame_cnt_next_s = frame_cnt_r + 32'd1;
    end
  end

  // Frame counter and registered tick, high while the counter sits at LIMIT.
  always_ff @(posedge proc_clk) begin
    if (reset) begin
      frame_cnt_r  <= 32'd0;
      frame_tick_r <= 1'b0;
    end else begin
      frame_cnt_r  <= frame_cnt_next_s;
      frame_tick_r <= (frame_cnt_next_s == LIMIT);
    end
  end

  // Two-flop synchroniser and per-key debounce counter.
  always_ff @(posedge proc_clk) begin
    if (reset) begin
      sync1_r <= '0;
      sync2_r <= '0;
      deb_r   <= '0;
      deb_d_r <= '0;
      for (int k = 0; k < int'(NUM_KEYS); k++) begin
        db_cnt_r[k] <= '0;
      end
    end else begin
      sync1_r <= keys;
      sync2_r <= sync1_r;
      deb_d_r <= deb_r;
      for (int k = 0; k < int'(NUM_KEYS); k++) begin
        if (sync2_r[k] == deb_r[k]) begin
          db_cnt_r[k] <= '0;
        end else if (db_cnt_r[k] == DB_LAST) begin
          deb_r[k]    <= sync2_r[k];
          db_cnt_r[k] <= '0;
        end else begin
          db_cnt_r[k] <= db_cnt_r[k] + 1'b1;
        end
      end
    end
  end

  // Cause set/clear vectors; a set on the same cycle as a clear wins.
  always_comb begin
    key_set_s  = '0;
    clr_s      = '0;
    ack_take_s = (state_r == ISSUE) && int_ack;
    for (int k = 0; k < int'(NUM_KEYS); k++) begin
      if (LEVEL_MODE != 1'b0) begin
        key_set_s[k] = frame_tick_r & deb_r[k] & key_mask[k];
      end else begin
        key_set_s[k] = deb_r[k] & ~deb_d_r[k] & key_mask[k];
      end
    end
    for (int i = 0; i <= int'(NUM_KEYS); i++) begin
      clr_s[i] = ack_take_s && (cause_sel_r == 5'(i));
    end
    set_s          = {key_set_s, frame_tick_r};
    pending_next_s = (pending_r & ~clr_s) | set_s;
  end

  // Saturating count of frame ticks that found the frame cause still pending.
  always_ff @(posedge proc_clk) begin
    if (reset) begin
      missed_r <= 8'd0;
    end else if (frame_tick_r && pending_r[0] && !clr_s[0] && (missed_r != 8'hFF)) begin
      missed_r <= missed_r + 8'd1;
    end else begin
      missed_r <= missed_r;
    end
  end

  // Issue FSM next-state and next-output logic.
  always_comb begin
    state_next_s = state_r;
    valid_next_s = valid_r;
    instr_next_s = instr_r;
    cause_next_s = cause_sel_r;
    pick_s       = pick_cause(pending_r);
    case (state_r)
      IDLE: begin
        if (|pending_r) begin
          cause_next_s = pick_s;
          valid_next_s = 1'b1;
          instr_next_s = {INT_OPCODE, 22'd0, pick_s};
          state_next_s = ISSUE;
        end else begin
          state_next_s = IDLE;
        end
      end
      ISSUE: begin
        if (int_ack) begin
          valid_next_s = 1'b0;
          instr_next_s = 32'd0;
          state_next_s = GAP;
        end else begin
          state_next_s = ISSUE;
        end
      end
      GAP: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
        valid_next_s = 1'b0;
        instr_next_s = 32'd0;
      end
    endcase
  end

  // FSM state, pending causes and registered handshake outputs.
  always_ff @(posedge proc_clk) begin
    if (reset) begin
      state_r     <= IDLE;
      valid_r     <= 1'b0;
      instr_r     <= 32'd0;
      cause_sel_r <= 5'd0;
      pending_r   <= '0;
    end else begin
      state_r     <= state_next_s;
      valid_r     <= valid_next_s;
      instr_r     <= instr_next_s;
      cause_sel_r <= cause_next_s;
      pending_r   <= pending_next_s;
    end
  end

  assign int_valid             = valid_r;
  assign interrupt_instruction = instr_r;
  assign frame_tick            = frame_tick_r;
  assign pending               = pending_r;
  assign missed_frames         = missed_r;

endmodule

// File: tb/tb_input_interrupt_arbiter.sv
// Self-checking bench for input_interrupt_arbiter: directed scenarios plus a
// randomized run compared against a cycle-level behavioural model.
module tb_input_interrupt_arbiter;

  localparam int PERIOD = 10;   // CLK_FREQ / FRAME_RATE
  localparam int LIM    = 9;
  localparam int DB     = 4;

  logic        proc_clk = 1'b0;
  logic        reset    = 1'b1;
  logic [3:0]  keys     = 4'd0;
  logic [3:0]  key_mask = 4'hF;
  logic        int_ack  = 1'b0;
  logic        int_valid;
  logic [31:0] interrupt_instruction;
  logic        frame_tick;
  logic [4:0]  pending;
  logic [7:0]  missed_frames;

  logic [3:0]  lvl_keys = 4'd0;
  logic [3:0]  lvl_mask = 4'hF;
  logic        lvl_ack  = 1'b1;
  logic        lvl_valid;
  logic [31:0] lvl_instr;
  logic        lvl_tick;
  logic [4:0]  lvl_pending;
  logic [7:0]  lvl_missed;

  int n_vec = 0;
  int n_err = 0;

  input_interrupt_arbiter #(.CLK_FREQ(1000), .FRAME_RATE(100), .NUM_KEYS(4),
    .DEBOUNCE_CYCLES(4), .LEVEL_MODE(1'b0), .INT_OPCODE(5'b11111)) dut (
    .proc_clk(proc_clk), .reset(reset), .keys(keys), .key_mask(key_mask),
    .int_ack(int_ack), .int_valid(int_valid),
    .interrupt_instruction(interrupt_instruction), .frame_tick(frame_tick),
    .pending(pending), .missed_frames(missed_frames));

  input_interrupt_arbiter #(.CLK_FREQ(1000), .FRAME_RATE(100), .NUM_KEYS(4),
    .DEBOUNCE_CYCLES(4), .LEVEL_MODE(1'b1), .INT_OPCODE(5'b11111)) dut_lvl (
    .proc_clk(proc_clk), .reset(reset), .keys(lvl_keys), .key_mask(lvl_mask),
    .int_ack(lvl_ack), .int_valid(lvl_valid),
    .interrupt_instruction(lvl_instr), .frame_tick(lvl_tick),
    .pending(lvl_pending), .missed_frames(lvl_missed));

  always #5 proc_clk = ~proc_clk;

  // Behavioural model of the edge-mode instance.
  int          m_cyc;
  bit          m_tick;
  bit [4:0]    m_pend;
  int          m_missed;
  bit          m_valid;
  bit [31:0]   m_instr;
  int          m_cause;
  int          m_gap;
  bit [3:0]    m_s1, m_s2, m_deb, m_dprev;
  int          m_mm [4];

  task automatic model_edge();
    bit       o_tick, o_valid;
    bit [4:0] o_pend, setb, clrb;
    bit [3:0] o_s2, o_deb, o_dp;
    int       o_cause, pick;
    if (reset) begin
      m_cyc = 0; m_tick = 0; m_pend = 0; m_missed = 0; m_valid = 0;
      m_instr = 0; m_cause = 0; m_gap = 0; m_s1 = 0; m_s2 = 0; m_deb = 0;
      m_dprev = 0;
      for (int k = 0; k < 4; k++) m_mm[k] = 0;
    end else begin
      o_tick = m_tick; o_valid = m_valid; o_pend = m_pend; o_cause = m_cause;
      o_s2 = m_s2; o_deb = m_deb; o_dp = m_dprev;
      m_cyc++;
      m_tick = ((m_cyc % PERIOD) == LIM);
      setb = 5'd0;
      setb[0] = o_tick;
      for (int k = 0; k < 4; k++) setb[k+1] = o_deb[k] & ~o_dp[k] & key_mask[k];
      clrb = 5'd0;
      if (o_valid && int_ack) clrb[o_cause] = 1'b1;
      if (o_tick && o_pend[0] && !clrb[0] && m_missed < 255) m_missed++;
      m_pend = (o_pend & ~clrb) | setb;
      if (o_valid) begin
        if (int_ack) begin m_valid = 0; m_instr = 32'd0; m_gap = 1; end
      end else if (m_gap > 0) begin
        m_gap--;
      end else if (o_pend != 5'd0) begin
        pick = 0;
        for (int k = 3; k >= 0; k--) if (o_pend[k+1]) pick = k + 1;
        m_cause = pick;
        m_valid = 1;
        m_instr = {5'b11111, 22'd0, 5'(pick)};
      end
      for (int k = 0; k < 4; k++) begin
        if (o_s2[k] != o_deb[k]) begin
          m_mm[k]++;
          if (m_mm[k] == DB) begin m_deb[k] = o_s2[k]; m_mm[k] = 0; end
        end else begin
          m_mm[k] = 0;
        end
      end
      m_dprev = o_deb;
      m_s2 = m_s1;
      m_s1 = keys;
    end
  endtask

  task automatic step();
    @(posedge proc_clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; keys = 4'd0; lvl_keys = 4'd0; key_mask = 4'hF;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (int_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b expected 0", int_valid); end
    n_vec++; if (interrupt_instruction !== 32'd0) begin n_err++; $display("FAIL reset_instr: got %h expected 0", interrupt_instruction); end
    n_vec++; if (frame_tick !== 1'b0) begin n_err++; $display("FAIL reset_tick: got %0b expected 0", frame_tick); end
    n_vec++; if (pending !== 5'd0) begin n_err++; $display("FAIL reset_pending: got %h expected 0", pending); end
    n_vec++; if (missed_frames !== 8'd0) begin n_err++; $display("FAIL reset_missed: got %0d expected 0", missed_frames); end
  endtask

  task automatic test_frame();
    bit exp_tick, exp_valid;
    do_reset(); int_ack = 1'b1;
    for (int i = 0; i < 35; i++) begin
      step();
      exp_tick  = (m_cyc == 9) || (m_cyc == 19) || (m_cyc == 29);
      exp_valid = (m_cyc == 11) || (m_cyc == 21) || (m_cyc == 31);
      n_vec++; if (frame_tick !== exp_tick) begin n_err++; $display("FAIL frame_tick c%0d: got %0b expected %0b", m_cyc, frame_tick, exp_tick); end
      n_vec++; if (int_valid !== exp_valid) begin n_err++; $display("FAIL frame_valid c%0d: got %0b expected %0b", m_cyc, int_valid, exp_valid); end
      if (exp_valid) begin
        n_vec++; if (interrupt_instruction !== 32'hF800_0000) begin n_err++; $display("FAIL frame_instr: got %h expected f8000000", interrupt_instruction); end
      end
    end
    n_vec++; if (missed_frames !== 8'd0) begin n_err++; $display("FAIL frame_missed: got %0d expected 0", missed_frames); end
  endtask

  task automatic test_key_edge();
    int cnt;
    do_reset(); int_ack = 1'b1; keys = 4'b0100; cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (m_cyc == 10) keys = 4'd0;
      if (m_cyc == 8) begin
        n_vec++; if (interrupt_instruction !== 32'hF800_0003) begin n_err++; $display("FAIL key_latency: got %h expected f8000003", interrupt_instruction); end
      end
      if (int_valid && interrupt_instruction == 32'hF800_0003) cnt++;
    end
    n_vec++; if (cnt !== 1) begin n_err++; $display("FAIL key_once: got %0d expected 1", cnt); end
    cnt = 0; keys = 4'b0100;
    for (int i = 0; i < 30; i++) begin
      step();
      if (i == 2) keys = 4'd0;
      if (int_valid && interrupt_instruction == 32'hF800_0003) cnt++;
    end
    n_vec++; if (cnt !== 0) begin n_err++; $display("FAIL key_bounce: got %0d expected 0", cnt); end
  endtask

  task automatic test_coincide();
    logic [31:0] seq [$];
    int gaps [$];
    int idle;
    do_reset(); int_ack = 1'b1; idle = 0;
    step(); step(); step();
    keys = 4'b1001;
    while (m_cyc < 18) begin
      step();
      if (int_valid) begin
        if (seq.size() > 0) gaps.push_back(idle);
        seq.push_back(interrupt_instruction);
        idle = 0;
      end else begin
        idle++;
      end
    end
    keys = 4'd0;
    n_vec++; if (seq.size() !== 3) begin n_err++; $display("FAIL order_count: got %0d expected 3", seq.size()); end
    if (seq.size() == 3) begin
      n_vec++; if (seq[0] !== 32'hF800_0001) begin n_err++; $display("FAIL order_0: got %h expected f8000001", seq[0]); end
      n_vec++; if (seq[1] !== 32'hF800_0004) begin n_err++; $display("FAIL order_1: got %h expected f8000004", seq[1]); end
      n_vec++; if (seq[2] !== 32'hF800_0000) begin n_err++; $display("FAIL order_2: got %h expected f8000000", seq[2]); end
      n_vec++; if (gaps[0] !== 2 || gaps[1] !== 2) begin n_err++; $display("FAIL order_gap: got %0d,%0d expected 2,2", gaps[0], gaps[1]); end
    end
  endtask

  task automatic wait_valid(input string tag);
    int budget;
    budget = 0;
    while (!int_valid && budget < 30) begin step(); budget++; end
    n_vec++; if (int_valid !== 1'b1) begin n_err++; $display("FAIL %s_wait: got %0b expected 1", tag, int_valid); end
  endtask

  task automatic test_ack_hold();
    do_reset(); int_ack = 1'b0;
    wait_valid("hold");
    for (int i = 0; i < 25; i++) begin
      step();
      n_vec++; if (int_valid !== 1'b1 || interrupt_instruction !== 32'hF800_0000) begin n_err++; $display("FAIL hold_stable: got %0b/%h expected 1/f8000000", int_valid, interrupt_instruction); end
    end
    n_vec++; if (missed_frames !== 8'd2) begin n_err++; $display("FAIL hold_missed: got %0d expected 2", missed_frames); end
    int_ack = 1'b1; step(); int_ack = 1'b0;
    n_vec++; if (int_valid !== 1'b0 || pending[0] !== 1'b0) begin n_err++; $display("FAIL hold_clear: got %0b/%0b expected 0/0", int_valid, pending[0]); end
  endtask

  task automatic test_mask_and_level();
    int cnt, lcnt;
    do_reset(); int_ack = 1'b1; key_mask = 4'b1101; keys = 4'b0010;
    lvl_keys = 4'b0010; cnt = 0; lcnt = 0;
    for (int i = 0; i < 35; i++) begin
      step();
      n_vec++; if (pending[2] !== 1'b0) begin n_err++; $display("FAIL mask_pending c%0d: got %0b expected 0", m_cyc, pending[2]); end
      if (int_valid && interrupt_instruction == 32'hF800_0002) cnt++;
      if (lvl_valid && lvl_instr == 32'hF800_0002) lcnt++;
      if (m_cyc == 11) begin
        n_vec++; if (lvl_instr !== 32'hF800_0002) begin n_err++; $display("FAIL level_first: got %h expected f8000002", lvl_instr); end
      end
    end
    n_vec++; if (cnt !== 0) begin n_err++; $display("FAIL mask_issue: got %0d expected 0", cnt); end
    n_vec++; if (lcnt !== 3) begin n_err++; $display("FAIL level_count: got %0d expected 3", lcnt); end
    keys = 4'd0; lvl_keys = 4'd0; key_mask = 4'hF;
  endtask

  task automatic test_reset_mid();
    do_reset(); int_ack = 1'b0;
    while (m_cyc < 22) step();
    n_vec++; if (missed_frames !== 8'd1 || int_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre: got %0d/%0b expected 1/1", missed_frames, int_valid); end
    reset = 1'b1; step(); reset = 1'b0;
    n_vec++; if (int_valid !== 1'b0 || interrupt_instruction !== 32'd0) begin n_err++; $display("FAIL mid_valid: got %0b/%h expected 0/0", int_valid, interrupt_instruction); end
    n_vec++; if (pending !== 5'd0 || missed_frames !== 8'd0) begin n_err++; $display("FAIL mid_state: got %h/%0d expected 0/0", pending, missed_frames); end
    for (int i = 0; i < 12; i++) begin
      step();
      n_vec++; if (frame_tick !== (m_cyc == 9)) begin n_err++; $display("FAIL mid_tick c%0d: got %0b expected %0b", m_cyc, frame_tick, (m_cyc == 9)); end
    end
  endtask

  task automatic test_saturate();
    do_reset(); int_ack = 1'b0;
    while (m_cyc < 2000) step();
    n_vec++; if (missed_frames !== 8'd199) begin n_err++; $display("FAIL sat_mid: got %0d expected 199", missed_frames); end
    while (m_cyc < 2700) step();
    n_vec++; if (missed_frames !== 8'd255) begin n_err++; $display("FAIL sat_top: got %0d expected 255", missed_frames); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) reset = 1'b1; else reset = 1'b0;
      for (int k = 0; k < 4; k++) if ($urandom_range(0, 5) == 0) keys[k] = ~keys[k];
      if ($urandom_range(0, 49) == 0) key_mask = 4'($urandom);
      int_ack = ($urandom_range(0, 2) != 0);
      step();
      n_vec++;
      if (int_valid !== m_valid || interrupt_instruction !== m_instr || frame_tick !== m_tick ||
          pending !== m_pend || missed_frames !== 8'(m_missed)) begin
        n_err++;
        $display("FAIL random c%0d: got v%0b i%h t%0b p%h m%0d expected v%0b i%h t%0b p%h m%0d",
                 m_cyc, int_valid, interrupt_instruction, frame_tick, pending, missed_frames,
                 m_valid, m_instr, m_tick, m_pend, m_missed);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_frame();
    test_key_edge();
    test_coincide();
    test_ack_hold();
    test_mask_and_level();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/input_interrupt_arbiter.md
Name: input_interrupt_arbiter

Overview:
- Parametrised successor to the single-key frame-rate interrupt source.
- Generates the game frame tick from proc_clk and synchronises and debounces NUM_KEYS key inputs.
- Latches key and frame events as sticky pending causes and issues one interrupt instruction at a time to the CPU with a valid/ack handshake, so no event is lost to a one-cycle pulse.
- Sits between the board key inputs and the processor interrupt port.

Parameters:
- CLK_FREQ, 50000000: proc_clk frequency in Hz.
- FRAME_RATE, 60: frame ticks per second.
- NUM_KEYS, 4: number of key inputs (1..30).
- DEBOUNCE_CYCLES, 16: cycles a synchronised key must be stable before its debounced value changes (>=1).
- LEVEL_MODE, 0:
  - 0 = a key raises its cause on the debounced rising edge.
  - 1 = a key raises its cause at each frame tick while it is held.
- INT_OPCODE, 5'b11111: opcode placed in instruction bits [31:27].

Ports:
- proc_clk, input, 1: system clock; all logic on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- keys, input, NUM_KEYS: raw asynchronous key levels, active-high.
- key_mask, input, NUM_KEYS: 1 = key enabled. A masked key never sets pending; an already-pending bit stays set.
- int_ack, input, 1: CPU accepts the presented instruction.
- int_valid, output, 1: interrupt_instruction is valid.
- interrupt_instruction, output, 32: instruction presented to the CPU.
- frame_tick, output, 1: one-cycle pulse per frame.
- pending, output, NUM_KEYS+1: bit 0 = frame cause; bit k+1 = key k.
- missed_frames, output, 8: saturating count of frame ticks dropped because the frame cause was already pending.

Behaviour:
- Reset: synchronous, active-high; all state cleared on the first proc_clk edge with reset high, including mid-handshake. Outputs after reset:
  - int_valid=0, interrupt_instruction=0, frame_tick=0, pending=0, missed_frames=0.
  - Frame counter=0, debounced key state=0, synchronisers=0, FSM=IDLE.
- Frame counter:
  - LIMIT = CLK_FREQ/FRAME_RATE - 1, integer division, 32-bit arithmetic.
  - Counts 0..LIMIT. frame_tick=1 for the single cycle with counter==LIMIT; the counter wraps to 0 on the next edge.
  - First tick is at cycle LIMIT after reset deasserts.
- Key path:
  - Two-flop synchroniser per key.
  - Debounce counter per key: resets to 0 whenever the synchronised value equals the debounced value; otherwise increments.
  - When the count reaches DEBOUNCE_CYCLES-1, the debounced value takes the synchronised value and the counter clears.
- Cause set rules, per cycle:
  - Frame cause: pending[0] set on frame_tick. If pending[0] is already 1 and not being cleared this cycle, missed_frames increments, saturating at 255.
  - LEVEL_MODE=0: pending[k+1] set on the debounced 0->1 transition when key_mask[k]=1.
  - LEVEL_MODE=1: pending[k+1] set on frame_tick when debounced key k=1 and key_mask[k]=1.
  - A set and a clear on the same bit in the same cycle: the set wins; the bit stays 1 and the event is re-issued later.
- Priority: key 0 highest, then ascending key index; frame cause lowest.
- FSM:
  - IDLE: if any pending bit is set, latch the highest-priority cause into cause_sel, drive int_valid=1 with the instruction on the next edge, and go to ISSUE. Otherwise stay.
  - ISSUE: int_valid=1 and interrupt_instruction are held stable until int_ack=1 is sampled. On that edge, clear pending[cause_sel], drive int_valid=0 and interrupt_instruction=0, and go to GAP.
  - GAP: one idle cycle, then IDLE.
  - Minimum spacing between consecutive valid instructions: 2 cycles of int_valid=0.
  - int_ack while int_valid=0 is ignored.
- Instruction format:
  - [31:27] = INT_OPCODE; [26:5] = 0.
  - [4:0] = cause code: 0 = frame; k+1 = key k.
- Latency:
  - Edge-mode key press: synchroniser 2 cycles + debounce DEBOUNCE_CYCLES cycles + pending 1 cycle + issue 1 cycle, when the FSM is idle.
  - Frame tick to int_valid: 2 cycles when the FSM is idle.

Test Plan:
- Use CLK_FREQ=1000, FRAME_RATE=100 (LIMIT=9), NUM_KEYS=4, DEBOUNCE_CYCLES=4, LEVEL_MODE=0, key_mask=4'hF, int_ack tied 1 one cycle after valid, unless noted.
- Reset released, no keys -> frame_tick at cycles 9, 19, 29. Each tick is followed by int_valid with instruction 0xF8000000, acknowledged; missed_frames stays 0.
- keys[2] high, held 10 cycles -> exactly one instruction 0xF8000003. A bounce shorter than 4 cycles produces none.
- keys[0] and keys[3] rise together, coinciding with a frame tick -> issue order 0xF8000001, 0xF8000004, 0xF8000000, each separated by 2 idle cycles.
- int_ack held 0 for 25 cycles while a frame cause is being issued -> instruction stays 0xF8000000 and stable; missed_frames reaches 2. After ack, the frame cause clears.
- key_mask[1]=0 and keys[1] pressed -> no cause, pending[2]=0. LEVEL_MODE=1 with keys[1] held and unmasked -> one 0xF8000002 per frame tick.
- reset asserted for 1 cycle while int_valid=1 -> next cycle: int_valid=0, pending=0, missed_frames=0, next frame_tick at cycle LIMIT after release.
